// File: rtl/maxpool_stream_ctrl_if.sv
// Pixel stream in / pooled stream out for maxpool_stream_ctrl.
//
// Both streams use the same valid/ready handshake. A transfer happens on a
// rising clock edge where valid and ready are both 1. Once valid is raised,
// the sender keeps it and its payload stable until that transfer happens.
// Ready may depend on valid combinationally. Valid never depends on ready.
//
// Modport roles:
// - master: the surroundings. They drive pixels in and accept pooled results.
// - slave: the pooling block.
interface maxpool_stream_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/maxpool_stream_ctrl.sv
// 2x2 / stride-2 max pooling over a raster-order pixel stream.
// Even rows go into a one-row line buffer. On odd rows, the even-column pixel
// is kept in a left register. The odd-column pixel then completes a 2x2 patch.
// That patch's maximum is registered onto the output stream.
module maxpool_stream_ctrl #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    maxpool_stream_ctrl_if.slave  s,
    output logic                  busy,
    output logic                  frame_done,
    output logic [1:0]            state_dbg
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              frame_done_q, frame_done_d;
    logic [DATA_W-1:0] linebuf_q [IMG_W];

    logic              in_ready;
    logic              accept;
    logic              lb_we;
    logic [DATA_W-1:0] pool_max;

    // Largest of the four pixels of the patch being completed this cycle.
    always_comb begin
        logic [DATA_W-1:0] top_max;
        logic [DATA_W-1:0] bot_max;
        top_max  = linebuf_q[{col_q[CW-1:1], 1'b0}];
        if (linebuf_q[col_q] > top_max) top_max = linebuf_q[col_q];
        bot_max  = (s.in_data > left_q) ? s.in_data : left_q;
        pool_max = (bot_max > top_max) ? bot_max : top_max;
    end

    // Next state: raster counters, patch assembly, output register and FSM.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        left_d       = left_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;

        // Accept input only while the output slot is free or draining.
        // This ensures a new result never overwrites one that has not been taken.
        in_ready = (state_q == S_RUN) && (!out_valid_q || s.out_ready);
        accept   = s.in_valid && in_ready;

        if (out_valid_q && s.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (!row_q[0]) begin
                        lb_we = 1'b1;
                    end else if (!col_q[0]) begin
                        left_d = s.in_data;
                    end else begin
                        out_data_d  = pool_max;
                        out_valid_d = 1'b1;
                        out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
                    end
                    if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Only the final pooled pixel can be pending here.
                if (out_valid_q && s.out_ready) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            left_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            left_q       <= left_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Even-row line buffer. Stale contents are always overwritten before being read.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[col_q] <= s.in_data;
        end
    end

    assign s.in_ready   = in_ready;
    assign s.out_valid  = out_valid_q;
    assign s.out_data   = out_data_q;
    assign s.out_last   = out_last_q;
    assign busy         = (state_q != S_IDLE);
    assign frame_done   = frame_done_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// Bench for maxpool_stream_ctrl.
// Two instances are used: dut_a is 4x4 and dut_b is 8x8.
// They share the stimulus signals. Only the selected instance sees start.
// Expected outputs come from a frame-level pooling model.
module tb_maxpool_stream_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic sel;
    logic in_valid;
    logic [7:0] in_data;
    logic out_ready;

    always #5 clk = ~clk;

    maxpool_stream_ctrl_if #(.DATA_W(8)) ifa ();
    maxpool_stream_ctrl_if #(.DATA_W(8)) ifb ();

    logic bz_a, bz_b, fd_a, fd_b;
    logic [1:0] st_a, st_b;

    assign ifa.in_valid  = in_valid;
    assign ifa.in_data   = in_data;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_data   = in_data;
    assign ifb.out_ready = out_ready;

    maxpool_stream_ctrl #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .s(ifa.slave),
        .busy(bz_a), .frame_done(fd_a), .state_dbg(st_a)
    );

    maxpool_stream_ctrl #(.IMG_W(8), .IMG_H(8), .DATA_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .s(ifb.slave),
        .busy(bz_b), .frame_done(fd_b), .state_dbg(st_b)
    );

    logic ov, ol, ir, fd, bz;
    logic [7:0] od;
    assign ov = sel ? ifb.out_valid : ifa.out_valid;
    assign ol = sel ? ifb.out_last  : ifa.out_last;
    assign od = sel ? ifb.out_data  : ifa.out_data;
    assign ir = sel ? ifb.in_ready  : ifa.in_ready;
    assign fd = sel ? fd_b : fd_a;
    assign bz = sel ? bz_b : bz_a;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] pix [64];
    logic [7:0] in_q[$];
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Build a frame and its expected pooled sequence.
    // kind 0: ramp. kind 1: all 0x80.
    // kind 2: each 2x2 patch has 0xFF in a different position.
    // kind 3: random pixels.
    task automatic build_frame(input int w, input int h, input int kind);
        in_q.delete();
        exp_q.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int k;
                int pos;
                k   = (r / 2) * (w / 2) + (c / 2);
                pos = (r % 2) * 2 + (c % 2);
                case (kind)
                    0:       pix[r*w+c] = 8'((r * w + c) & 8'hff);
                    1:       pix[r*w+c] = 8'h80;
                    2:       pix[r*w+c] = (pos == k % 4) ? 8'hff : 8'h00;
                    default: pix[r*w+c] = 8'($urandom_range(0, 255));
                endcase
                in_q.push_back(pix[r*w+c]);
            end
        end
        for (int pr = 0; pr < h / 2; pr++) begin
            for (int pc = 0; pc < w / 2; pc++) begin
                logic [7:0] m;
                m = 8'h00;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (pix[(2*pr+dr)*w + 2*pc+dc] > m) m = pix[(2*pr+dr)*w + 2*pc+dc];
                exp_q.push_back({(pr == h/2-1) && (pc == w/2-1), m});
            end
        end
    endtask

    // Run one frame on the selected instance.
    // or_mode 0: out_ready is always 1.
    // or_mode 1: out_ready is 0 for 3 cycles after the first output appears.
    // or_mode 2: out_ready is random.
    task automatic run_frame(input int w, input int h, input int kind, input bit iv_rand,
                             input int or_mode, input bit start_mid);
        int cyc;
        int stall_left;
        int got;
        bit first_seen;
        bit prev_hs_last;
        bit prev_stall;
        bit done;
        bit acc;
        logic [7:0] held_d;
        logic held_l;
        logic [8:0] e;
        build_frame(w, h, kind);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; stall_left = 0; got = 0; first_seen = 0;
        prev_hs_last = 0; prev_stall = 0; done = 0;
        held_d = '0; held_l = 1'b0;
        while (!done && cyc < 3000) begin
            if (or_mode == 1 && ov === 1'b1 && !first_seen) begin
                first_seen = 1;
                stall_left = 3;
            end
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (stall_left == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (stall_left > 0) stall_left--;
            in_valid = (in_q.size() > 0) && (iv_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            in_data  = (in_q.size() > 0) ? in_q[0] : 8'($urandom_range(0, 255));
            start    = start_mid && (cyc == 5);
            #1;
            check("frame_done", {31'd0, fd}, {31'd0, prev_hs_last});
            if (fd === 1'b1) begin
                check("busy_after_done", {31'd0, bz}, 32'd0);
                done = 1;
            end
            if (ov === 1'b1 && !out_ready) check("in_ready_stall", {31'd0, ir}, 32'd0);
            if (prev_stall) begin
                check("hold_data", {24'd0, od}, {24'd0, held_d});
                check("hold_last", {31'd0, ol}, {31'd0, held_l});
            end
            prev_hs_last = 0;
            if (ov === 1'b1 && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {24'd0, od}, {24'd0, e[7:0]});
                    check("out_last", {31'd0, ol}, {31'd0, e[8]});
                    prev_hs_last = e[8];
                end
                got++;
            end
            acc        = in_valid && (ir === 1'b1);
            prev_stall = (ov === 1'b1) && !out_ready;
            held_d     = od;
            held_l     = ol;
            @(posedge clk);
            if (acc) void'(in_q.pop_front());
            @(negedge clk);
            cyc++;
        end
        check("frame_timeout", {31'd0, done}, 32'd1);
        check("out_count", got, (w / 2) * (h / 2));
        check("exp_left", exp_q.size(), 32'd0);
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, {31'd0, ov}, 32'd0);
        check({tag, "_out_last"},  {31'd0, ol}, 32'd0);
        check({tag, "_out_data"},  {24'd0, od}, 32'd0);
        check({tag, "_frame_done"}, {31'd0, fd}, 32'd0);
        check({tag, "_busy"},      {31'd0, bz}, 32'd0);
        check({tag, "_in_ready"},  {31'd0, ir}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #1;
        check_reset_values("rst_a");
        sel = 1'b1;
        #1;
        check_reset_values("rst_b");
        sel = 1'b0;
        #20;
        @(negedge clk);
        rst = 1'b0;

        // in_valid held high in IDLE: nothing is accepted.
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("idle_in_ready", {31'd0, ir}, 32'd0);
            check("idle_busy", {31'd0, bz}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;

        // 4x4 frames on dut_a.
        run_frame(4, 4, 0, 1'b0, 0, 1'b0);
        run_frame(4, 4, 0, 1'b0, 1, 1'b0);
        run_frame(4, 4, 2, 1'b1, 2, 1'b0);
        run_frame(4, 4, 1, 1'b0, 0, 1'b1);

        // 8x8 frames on dut_b.
        sel = 1'b1;
        run_frame(8, 8, 0, 1'b1, 0, 1'b1);

        // Reset after 6 pixels of a frame.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("post_rst_in_ready", {31'd0, ir}, 32'd0);
            check("post_rst_busy", {31'd0, bz}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        run_frame(8, 8, 0, 1'b1, 2, 1'b0);
        run_frame(8, 8, 3, 1'b1, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
